// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if
// CSR bus bundle between the CPLD register decoder and irq_ctrl.
//   csr_a   [4:0]  register address          (master -> slave)
//   csr_di  [7:0]  write data                (master -> slave)
//   csr_we         one-cycle write strobe    (master -> slave)
//   csr_do  [7:0]  combinational read data   (slave -> master)
// -----------------------------------------------------------------------------
interface irq_ctrl_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (
    output csr_a,
    output csr_di,
    output csr_we,
    input  csr_do
  );

  modport slave (
    input  csr_a,
    input  csr_di,
    input  csr_we,
    output csr_do
  );
endinterface

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Interrupt aggregator on the CPLD CSR bus. Up to eight sources, each with an
// enable bit, a level/rising-edge mode bit and a pending bit (edge bits are
// write-1-to-clear). The single registered irq_out is forced low for
// GAP_CYCLES after each acknowledge (write to IP) so edge-sensitive SoC inputs
// see a fresh rising edge when interrupts remain active.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   bus      CSR bus (irq_ctrl_if.slave): csr_a, csr_di, csr_we, csr_do
//   irq_in   [7:0] source requests, active-high
//   irq_out  aggregated interrupt, active-high, registered
//
// Register map (offset from BASE_ADDR; offsets wrap modulo 32):
//   +0 IE      enable mask, R/W
//   +1 EDGE    1 = rising-edge mode, 0 = level mode, R/W
//   +2 IP      pending; write 1 clears edge-mode bits
//   +3 ACTIVE  IP & IE, read-only
// Bits at or above NUM_IRQS read 0 and ignore writes.
//
// Build option:
//   IRQ_CTRL_SYNC_EN  when defined, irq_in passes through a 2-flop
//                     synchroniser per bit (irq_in->irq_out latency 4 instead
//                     of 2). Leave undefined for same-clock-domain sources.
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter logic [4:0] BASE_ADDR  = 5'h1f,
  parameter int         NUM_IRQS   = 8,
  parameter int         GAP_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  irq_ctrl_if.slave      bus,
  input  logic [7:0]     irq_in,
  output logic           irq_out
);

  localparam logic [7:0] IMPL_MASK = 8'((9'h001 << NUM_IRQS) - 9'h001);
  localparam bit         GAP_EN    = (GAP_CYCLES > 0);
  localparam logic [7:0] GAP_LOAD  = GAP_EN ? 8'(GAP_CYCLES - 1) : 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Address decode. The offset is computed modulo 32 so a block placed near
  // the top of the 5-bit space wraps around to address 0.
  logic [4:0] offset;
  logic       hit;
  logic       wr_ie;
  logic       wr_edge;
  logic       wr_ip;

  assign offset  = bus.csr_a - BASE_ADDR;
  assign hit     = (offset < 5'd4);
  assign wr_ie   = bus.csr_we && (offset == 5'd0);
  assign wr_edge = bus.csr_we && (offset == 5'd1);
  assign wr_ip   = bus.csr_we && (offset == 5'd2);

  logic [7:0] ie;
  logic [7:0] edge_mode;
  logic [7:0] ip;
  logic [7:0] s;
  logic [7:0] s_q;

  // ---- stage p0/p1: optional input synchroniser ----
`ifdef IRQ_CTRL_SYNC_EN
  logic [7:0] sync_p0;
  logic [7:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 8'h00;
      sync_p1 <= 8'h00;
    end else begin
      sync_p0 <= irq_in & IMPL_MASK;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1;
`else
  assign s = irq_in & IMPL_MASK;
`endif

  // ---- sample stage: s_q holds s from the previous cycle for edge detect ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 8'h00;
    end else begin
      s_q <= s;
    end
  end

  logic [7:0] rise;
  logic [7:0] ie_next;
  logic [7:0] edge_next;
  logic [7:0] edge_chg;
  logic [7:0] w1c;
  logic [7:0] ip_next;

  assign rise = s & ~s_q;

  always_comb begin
    ie_next   = wr_ie   ? (bus.csr_di & IMPL_MASK) : ie;
    edge_next = wr_edge ? (bus.csr_di & IMPL_MASK) : edge_mode;
    edge_chg  = edge_next ^ edge_mode;
    // Only edge-mode bits respond to W1C; level bits mirror the input.
    w1c       = wr_ip ? (bus.csr_di & IMPL_MASK & edge_mode) : 8'h00;
    // Rising edge beats a simultaneous W1C so no event is lost; a mode change
    // clears the bit for that cycle regardless of either.
    ip_next   = ~edge_chg & IMPL_MASK &
                ((edge_mode & (rise | (ip & ~w1c))) | (~edge_mode & s));
  end

  // ---- register stage: IE / EDGE / IP ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie        <= 8'h00;
      edge_mode <= 8'h00;
      ip        <= 8'h00;
    end else begin
      ie        <= ie_next;
      edge_mode <= edge_next;
      ip        <= ip_next;
    end
  end

  // Acknowledge is registered so the FSM reacts to the post-write state: the
  // gap (or the drop to IDLE) appears one cycle after the write edge.
  logic ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= wr_ip;
    end
  end

  logic active;
  assign active = |(ip & ie);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (active) begin
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (!active) begin
          state_next = IDLE;
        end else if (ack_q && GAP_EN) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end
      end
      GAP: begin
        // Acks arriving here are ignored so the gap length is never extended.
        if (cnt == 8'h00) begin
          state_next = active ? ASSERT : IDLE;
        end else begin
          cnt_next = cnt - 8'h01;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'h00;
      end
    endcase
  end

  // ---- output stage: irq_out is a flop driven from the next state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'h00;
      irq_out <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      irq_out <= (state_next == ASSERT);
    end
  end

  // Combinational read mux; 0 outside the block's four addresses.
  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (offset[1:0])
        2'd0:    rdata = ie;
        2'd1:    rdata = edge_mode;
        2'd2:    rdata = ip;
        default: rdata = ip & ie;
      endcase
    end
  end

  assign bus.csr_do = rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Self-checking bench for irq_ctrl. Two instances share the clock: dut with
// eight sources and dut4 with NUM_IRQS=4 (own reset, so it can be reset
// mid-gap). Expected values are pushed to queues when stimulus is applied and
// popped when the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int         GAP    = 4;
  localparam logic [4:0] BASE   = 5'h08;
  localparam logic [4:0] A_IE   = BASE;
  localparam logic [4:0] A_EDGE = BASE + 5'd1;
  localparam logic [4:0] A_IP   = BASE + 5'd2;
  localparam logic [4:0] A_ACT  = BASE + 5'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst4_n;
  logic [7:0] irq_in;
  logic [7:0] irq_in4;
  logic       irq_out;
  logic       irq_out4;

  always #5 clk = ~clk;

  irq_ctrl_if bus ();
  irq_ctrl_if bus4 ();

  irq_ctrl #(.BASE_ADDR(BASE), .NUM_IRQS(8), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .irq_in(irq_in), .irq_out(irq_out)
  );

  irq_ctrl #(.BASE_ADDR(BASE), .NUM_IRQS(4), .GAP_CYCLES(GAP)) dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(bus4), .irq_in(irq_in4), .irq_out(irq_out4)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       irq_q[$];
  logic [7:0] got;
  logic [7:0] exp;
  logic       bexp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.csr_a  = a;
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic wr4(input logic [4:0] a, input logic [7:0] d);
    bus4.csr_a  = a;
    bus4.csr_di = d;
    bus4.csr_we = 1'b1;
    tick();
    bus4.csr_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    bus.csr_a = a;
    #1;
    d = bus.csr_do;
  endtask

  task automatic rd4(input logic [4:0] a, output logic [7:0] d);
    bus4.csr_a = a;
    #1;
    d = bus4.csr_do;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst4_n = 1'b0;
    irq_in = 8'h00; irq_in4 = 8'h00;
    bus.csr_a = 5'h00; bus.csr_di = 8'h00; bus.csr_we = 1'b0;
    bus4.csr_a = 5'h00; bus4.csr_di = 8'h00; bus4.csr_we = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; rst4_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      rd(5'(int'(BASE) + i), got);
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_reg+%0d: got %h, expected %h", i, got, exp);
      end
    end
    irq_q.push_back(1'b0);
    bexp = irq_q.pop_front();
    n_vec++;
    if (irq_out !== bexp) begin
      n_err++;
      $display("FAIL reset_irq_out: got %b, expected %b", irq_out, bexp);
    end
  endtask

  task automatic test_level();
    wr(A_IE, 8'h01);
    wr(A_EDGE, 8'h00);
    // Register readback plus out-of-range reads on both sides of the block.
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rd(A_IE, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL ie_readback: got %h, expected %h", got, exp); end
    rd(BASE - 5'd1, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL out_of_range_lo: got %h, expected %h", got, exp); end
    rd(BASE + 5'd4, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL out_of_range_hi: got %h, expected %h", got, exp); end

    for (int j = 0; j < 16; j++) begin
      exp_q.push_back(((j >= LAT - 2) && (j < 10 + LAT - 2)) ? 8'h01 : 8'h00);
      irq_q.push_back((j >= LAT - 1) && (j < 10 + LAT - 1));
    end
    irq_in[0] = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      rd(A_IP, got);
      exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL level_ip[%0d]: got %h, expected %h", j, got, exp); end
      bexp = irq_q.pop_front(); n_vec++;
      if (irq_out !== bexp) begin n_err++; $display("FAIL level_irq_out[%0d]: got %b, expected %b", j, irq_out, bexp); end
      if (j == 9) irq_in[0] = 1'b0;
    end
    wr(A_IE, 8'h00);
  endtask

  task automatic test_edge();
    wr(A_EDGE, 8'h04);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    repeat (LAT + 1) tick();
    // Masked bit still latches and keeps irq_out low.
    exp_q.push_back(8'h04); irq_q.push_back(1'b0);
    rd(A_IP, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL edge_masked_ip: got %h, expected %h", got, exp); end
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL edge_masked_irq: got %b, expected %b", irq_out, bexp); end
    // Enabling the pending bit raises irq_out one cycle after the write edge.
    irq_q.push_back(1'b0); irq_q.push_back(1'b1); irq_q.push_back(1'b1);
    wr(A_IE, 8'h04);
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL edge_enable_t0: got %b, expected %b", irq_out, bexp); end
    tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL edge_enable_t1: got %b, expected %b", irq_out, bexp); end
    repeat (3) tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL edge_hold: got %b, expected %b", irq_out, bexp); end
    exp_q.push_back(8'h04);
    rd(A_ACT, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL edge_active: got %h, expected %h", got, exp); end
    // W1C clears IP; irq_out drops one cycle after the write edge.
    exp_q.push_back(8'h00); irq_q.push_back(1'b1); irq_q.push_back(1'b0);
    wr(A_IP, 8'h04);
    rd(A_IP, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL edge_w1c_ip: got %h, expected %h", got, exp); end
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL edge_w1c_t0: got %b, expected %b", irq_out, bexp); end
    tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL edge_w1c_t1: got %b, expected %b", irq_out, bexp); end
  endtask

  task automatic test_gap();
    wr(A_EDGE, 8'h03);
    wr(A_IE, 8'h03);
    irq_in[1:0] = 2'b11;
    tick();
    irq_in[1:0] = 2'b00;
    repeat (LAT + 1) tick();
    exp_q.push_back(8'h03); irq_q.push_back(1'b1);
    rd(A_IP, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL gap_ip_pre: got %h, expected %h", got, exp); end
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL gap_irq_pre: got %b, expected %b", irq_out, bexp); end
    // Ack bit 0 with bit 1 still active: low for exactly GAP cycles.
    irq_q.push_back(1'b1);
    for (int j = 1; j <= GAP + 3; j++) irq_q.push_back(j > GAP);
    wr(A_IP, 8'h01);
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL gap_t0: got %b, expected %b", irq_out, bexp); end
    for (int j = 1; j <= GAP + 3; j++) begin
      // A second write to IP inside the gap must not restart it.
      if (j == 2) wr(A_IP, 8'h00);
      else tick();
      bexp = irq_q.pop_front(); n_vec++;
      if (irq_out !== bexp) begin n_err++; $display("FAIL gap_t%0d: got %b, expected %b", j, irq_out, bexp); end
    end
    exp_q.push_back(8'h02);
    rd(A_ACT, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL gap_active: got %h, expected %h", got, exp); end
    // Final ack leaves nothing active: drop to IDLE, no gap re-assert.
    irq_q.push_back(1'b1); irq_q.push_back(1'b0); irq_q.push_back(1'b0);
    wr(A_IP, 8'h02);
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL gap_last_t0: got %b, expected %b", irq_out, bexp); end
    tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL gap_last_t1: got %b, expected %b", irq_out, bexp); end
    repeat (GAP + 1) tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out !== bexp) begin n_err++; $display("FAIL gap_last_idle: got %b, expected %b", irq_out, bexp); end
  endtask

  task automatic test_set_wins();
    wr(A_EDGE, 8'h08);
    wr(A_IE, 8'h08);
    irq_in[3] = 1'b1;
    tick();
    irq_in[3] = 1'b0;
    repeat (LAT + 1) tick();
    exp_q.push_back(8'h08);
    rd(A_IP, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL setwins_pre: got %h, expected %h", got, exp); end
    // New rising edge sampled on the same edge as the W1C write.
    exp_q.push_back(8'h08);
    irq_in[3] = 1'b1;
    repeat (LAT - 2) tick();
    wr(A_IP, 8'h08);
    rd(A_IP, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL setwins_same_cycle: got %h, expected %h", got, exp); end
    irq_in[3] = 1'b0;
    repeat (LAT + 1) tick();
    exp_q.push_back(8'h00);
    wr(A_IP, 8'h08);
    rd(A_IP, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL setwins_plain_clear: got %h, expected %h", got, exp); end
    wr(A_IE, 8'h00);
    repeat (GAP + 2) tick();
  endtask

  task automatic test_num_irqs();
    exp_q.push_back(8'h0f); exp_q.push_back(8'h0f);
    wr4(A_IE, 8'hff);
    rd4(A_IE, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL n4_ie_mask: got %h, expected %h", got, exp); end
    wr4(A_EDGE, 8'hff);
    rd4(A_EDGE, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL n4_edge_mask: got %h, expected %h", got, exp); end
    wr4(A_EDGE, 8'h00);
    // Unimplemented inputs are ignored.
    exp_q.push_back(8'h00); irq_q.push_back(1'b0);
    irq_in4 = 8'hf0;
    repeat (LAT + 2) tick();
    rd4(A_IP, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL n4_upper_ip: got %h, expected %h", got, exp); end
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out4 !== bexp) begin n_err++; $display("FAIL n4_upper_irq: got %b, expected %b", irq_out4, bexp); end
    // Level source on bit 0: exact latency.
    irq_q.push_back(1'b0); irq_q.push_back(1'b1);
    irq_in4 = 8'h01;
    repeat (LAT - 1) tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out4 !== bexp) begin n_err++; $display("FAIL n4_latency_early: got %b, expected %b", irq_out4, bexp); end
    tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out4 !== bexp) begin n_err++; $display("FAIL n4_latency: got %b, expected %b", irq_out4, bexp); end
    // Ack with the level source still high enters the gap.
    irq_q.push_back(1'b1); irq_q.push_back(1'b0);
    wr4(A_IP, 8'h00);
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out4 !== bexp) begin n_err++; $display("FAIL n4_ack_t0: got %b, expected %b", irq_out4, bexp); end
    tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out4 !== bexp) begin n_err++; $display("FAIL n4_gap: got %b, expected %b", irq_out4, bexp); end
    // Asynchronous reset mid-gap clears everything immediately.
    #2;
    rst4_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      rd4(5'(int'(BASE) + i), got);
      exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL n4_rst_reg+%0d: got %h, expected %h", i, got, exp); end
    end
    // Without the reset the gap would have ended with irq_out4 high again.
    irq_q.push_back(1'b0);
    repeat (GAP + 2) tick();
    bexp = irq_q.pop_front(); n_vec++;
    if (irq_out4 !== bexp) begin n_err++; $display("FAIL n4_rst_irq: got %b, expected %b", irq_out4, bexp); end
    irq_in4 = 8'h00;
    rst4_n  = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_gap();
    test_set_wins();
    test_num_irqs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
